// File: rtl/signal_check_sched.sv
// signal_check_sched: time-shares one signal checker across N_CH channels.
//
// A start pulse (accepted only in IDLE) latches ch_mask_i and sweeps every
// enabled channel in ascending order. For each channel the sweep runs:
//   SETTLE (1 cycle, select stable, checker disabled),
//   CHECK  (CHECK_LEN cycles, checker enabled, fail cycles counted),
//   EVAL   (1 cycle, result folded into pass mask and fail total).
// After the last channel a one-cycle DONE pulse is issued. Abort drops
// back to IDLE without a done pulse, keeping only fully evaluated results.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start_i        sweep request pulse
//   abort_i        terminate a running sweep
//   ch_mask_i      channels to check, sampled when start is accepted
//   chk_match_i    checker match output
//   chk_fail_i     checker fail output
//   ch_sel_o       channel routed to the checker
//   chk_en_o       checker enable
//   busy_o         sweep in progress
//   done_o         one-cycle sweep completion pulse
//   pass_mask_o    per-channel pass result (1 = passed)
//   fail_total_o   saturating total of fail cycles over the sweep
module signal_check_sched #(
    parameter int N_CH      = 4,
    parameter int CHECK_LEN = 8,
    parameter int MAX_FAIL  = 0,
    parameter int CNT_W     = 8,
    localparam int SW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [N_CH-1:0]  ch_mask_i,
    input  logic             chk_match_i,
    input  logic             chk_fail_i,
    output logic [SW-1:0]    ch_sel_o,
    output logic             chk_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [N_CH-1:0]  pass_mask_o,
    output logic [CNT_W-1:0] fail_total_o
);

    localparam int WW = (CHECK_LEN > 1) ? $clog2(CHECK_LEN) : 1;
    localparam int FW = $clog2(CHECK_LEN + 1);
    localparam int TW = ((CNT_W > FW) ? CNT_W : FW) + 1;

    typedef enum logic [2:0] {IDLE, SETTLE, CHECK, EVAL, DONE} state_t;

    state_t           state_q, state_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [WW-1:0]    win_q, win_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [N_CH-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             chk_en_q, busy_q, done_q;
    logic             first_hit, next_hit;
    logic [SW-1:0]    first_idx, next_idx;
    logic [TW-1:0]    sum;
    logic             fail_now;

    // A disagreeing match/fail pair is treated as a failing cycle.
    assign fail_now = chk_fail_i | ~chk_match_i;
    assign sum      = TW'(total_q) + TW'(fcnt_q);

    // Descending scan so the last hit written is the lowest qualifying index.
    always_comb begin
        first_hit = 1'b0;
        first_idx = '0;
        next_hit  = 1'b0;
        next_idx  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) begin
                first_hit = 1'b1;
                first_idx = SW'(i);
            end
            if (mask_q[i] && i > int'(sel_q)) begin
                next_hit = 1'b1;
                next_idx = SW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        win_d   = win_q;
        fcnt_d  = fcnt_q;
        pass_d  = pass_q;
        total_d = total_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    mask_d  = ch_mask_i;
                    pass_d  = '0;
                    total_d = '0;
                    state_d = first_hit ? SETTLE : DONE;
                    sel_d   = first_hit ? first_idx : sel_q;
                end
            end
            SETTLE: state_d = CHECK;
            CHECK: begin
                fcnt_d = fcnt_q + FW'(fail_now);
                if (win_q == WW'(CHECK_LEN - 1)) begin
                    win_d   = '0;
                    state_d = EVAL;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            EVAL: begin
                pass_d[sel_q] = int'(fcnt_q) <= MAX_FAIL;
                total_d       = (sum > TW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
                fcnt_d        = '0;
                state_d       = next_hit ? SETTLE : DONE;
                sel_d         = next_hit ? next_idx : sel_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort discards the channel in flight, including one in EVAL.
        if (abort_i && (state_q == SETTLE || state_q == CHECK || state_q == EVAL)) begin
            state_d = IDLE;
            sel_d   = sel_q;
            win_d   = '0;
            fcnt_d  = '0;
            pass_d  = pass_q;
            total_d = total_q;
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            sel_q    <= '0;
            win_q    <= '0;
            fcnt_q   <= '0;
            pass_q   <= '0;
            total_q  <= '0;
            chk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            win_q    <= win_d;
            fcnt_q   <= fcnt_d;
            pass_q   <= pass_d;
            total_q  <= total_d;
            chk_en_q <= state_d == CHECK;
            busy_q   <= state_d == SETTLE || state_d == CHECK || state_d == EVAL;
            done_q   <= state_d == DONE;
        end
    end

    assign ch_sel_o     = sel_q;
    assign chk_en_o     = chk_en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_mask_o  = pass_q;
    assign fail_total_o = total_q;

endmodule

// File: tb/tb_signal_check_sched.sv
// tb_signal_check_sched: table-driven sweeps with a per-cycle expectation queue.
module tb_signal_check_sched;

    localparam int L = 8;
    localparam int P = L + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [3:0] ch_mask_i = '0;
    logic       chk_match_i, chk_fail_i;
    logic [1:0] ch_sel_o;
    logic       chk_en_o, busy_o, done_o;
    logic [3:0] pass_mask_o;
    logic [7:0] fail_total_o;

    logic [3:0] chan = 4'hF;
    logic       glitch = 1'b0;

    assign chk_fail_i  = ~chan[ch_sel_o] | glitch;
    assign chk_match_i = ~chk_fail_i;

    signal_check_sched #(.N_CH(4), .CHECK_LEN(L), .MAX_FAIL(0), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .ch_mask_i(ch_mask_i), .chk_match_i(chk_match_i), .chk_fail_i(chk_fail_i),
        .ch_sel_o(ch_sel_o), .chk_en_o(chk_en_o), .busy_o(busy_o), .done_o(done_o),
        .pass_mask_o(pass_mask_o), .fail_total_o(fail_total_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] chan;
        int         glitch_at;
        int         abort_at;
        int         start_at;
        logic [3:0] exp_pass;
        int         exp_total;
        int         exp_done;
        int         exp_en;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_sel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   en_list[$];
        int   k, last, en_cnt, done_cnt, done_cyc, j, ph;
        bit   ab;
        exp_t e;
        for (int i = 0; i < 4; i++) if (v.mask[i]) en_list.push_back(i);
        k  = en_list.size();
        ab = v.abort_at >= 1 && v.abort_at <= k * P;
        last = ab ? v.abort_at + 1 : k * P + 2;
        for (int c = 1; c <= last; c++) begin
            e = '{sel: 2'(last_sel), en: 1'b0, busy: 1'b0, done: 1'b0};
            if (ab && c > v.abort_at) begin
                e.sel = 2'(en_list[(v.abort_at - 1) / P]);
            end else if (c <= k * P) begin
                j = (c - 1) / P;
                ph = (c - 1) % P;
                e.sel  = 2'(en_list[j]);
                e.en   = ph >= 1 && ph <= L;
                e.busy = 1'b1;
            end else begin
                e.sel  = (k > 0) ? 2'(en_list[k - 1]) : 2'(last_sel);
                e.done = c == k * P + 1;
            end
            exp_q.push_back(e);
        end
        last_sel = int'(e.sel);
        en_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        chan = v.chan;
        ch_mask_i = v.mask;
        start_i = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            abort_i = 1'b0;
            glitch = 1'b0;
            ch_mask_i = ~v.mask;
            if (exp_q.size() == 0) begin
                chk($sformatf("v%0d c%0d queue", id, c), 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("v%0d c%0d ch_sel", id, c), 32'(ch_sel_o), 32'(e.sel));
                chk($sformatf("v%0d c%0d chk_en", id, c), 32'(chk_en_o), 32'(e.en));
                chk($sformatf("v%0d c%0d busy", id, c), 32'(busy_o), 32'(e.busy));
                chk($sformatf("v%0d c%0d done", id, c), 32'(done_o), 32'(e.done));
            end
            if (chk_en_o) en_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == v.abort_at) abort_i = 1'b1;
            if (c == v.glitch_at) glitch = 1'b1;
            if (c == v.start_at) start_i = 1'b1;
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        glitch = 1'b0;
        chk($sformatf("v%0d pass_mask", id), 32'(pass_mask_o), 32'(v.exp_pass));
        chk($sformatf("v%0d fail_total", id), 32'(fail_total_o), 32'(v.exp_total));
        chk($sformatf("v%0d chk_en cycles", id), 32'(en_cnt), 32'(v.exp_en));
        chk($sformatf("v%0d done pulses", id), 32'(done_cnt), (v.exp_done > 0) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d done cycle", id), 32'(done_cyc), 32'(v.exp_done));
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{4'hF, 4'hF, -1, -1, -1, 4'hF, 0, 41, 32};
        vecs[1] = '{4'hF, 4'hB, -1, -1, -1, 4'hB, 8, 41, 32};
        vecs[2] = '{4'h5, 4'hF, 4, -1, -1, 4'h4, 1, 21, 16};
        vecs[3] = '{4'h0, 4'hF, -1, -1, -1, 4'h0, 0, 1, 0};
        vecs[4] = '{4'hF, 4'hB, -1, 14, -1, 4'h1, 0, -1, 11};
        vecs[5] = '{4'hF, 4'hF, -1, -1, 15, 4'hF, 0, 41, 32};
        vecs[6] = '{4'hA, 4'h5, -1, -1, -1, 4'h0, 16, 21, 16};
        vecs[7] = '{4'h6, 4'hF, -1, 21, 5, 4'h6, 0, 21, 16};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ch_sel", 32'(ch_sel_o), 0);
        chk("reset chk_en", 32'(chk_en_o), 0);
        chk("reset busy", 32'(busy_o), 0);
        chk("reset done", 32'(done_o), 0);
        chk("reset pass_mask", 32'(pass_mask_o), 0);
        chk("reset fail_total", 32'(fail_total_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Abort together with start in IDLE: nothing starts.
        @(negedge clk);
        ch_mask_i = 4'hF;
        start_i = 1'b1;
        abort_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            abort_i = 1'b0;
            chk($sformatf("idle abort c%0d busy", c), 32'(busy_o), 0);
            chk($sformatf("idle abort c%0d done", c), 32'(done_o), 0);
            chk($sformatf("idle abort c%0d ch_sel", c), 32'(ch_sel_o), 32'(last_sel));
        end

        // Reset mid-CHECK of channel 1, with start asserted alongside it.
        @(negedge clk);
        chan = 4'hF;
        ch_mask_i = 4'hF;
        start_i = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("pre-reset ch_sel", 32'(ch_sel_o), 1);
        chk("pre-reset chk_en", 32'(chk_en_o), 1);
        chk("pre-reset pass_mask", 32'(pass_mask_o), 1);
        rst_n = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        chk("mid reset ch_sel", 32'(ch_sel_o), 0);
        chk("mid reset chk_en", 32'(chk_en_o), 0);
        chk("mid reset busy", 32'(busy_o), 0);
        chk("mid reset done", 32'(done_o), 0);
        chk("mid reset pass_mask", 32'(pass_mask_o), 0);
        chk("mid reset fail_total", 32'(fail_total_o), 0);
        rst_n = 1'b1;
        start_i = 1'b0;
        last_sel = 0;
        @(negedge clk);
        chk("post reset busy", 32'(busy_o), 0);

        run_vec(vecs[1], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
